or4_response_checker: RTL and testbench
=======================================

Name: or4_response_checker

Overview:
- Self-checking monitor at the observing end of the four-input OR-gate test interface.
- The stimulus side drives A..D, and the gate under test returns E = A|B, F = C|D, G = A|B|C|D.
- On each sample strobe, this block latches the stimulus, waits a settle interval, then compares the E/F/G responses against locally computed expected values.
- It counts samples and mismatches, captures the first failing vector, and reports PASS/DONE after a programmed number of samples.

Parameters:
- NUM_SAMPLES, 16, number of strobed vectors checked per run (1..255).
- SETTLE, 2, clock cycles between latching the stimulus and comparing the responses (1..15).
- ERR_W, 8, width of the error counter.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- STROBE  input  1  one-cycle pulse; the current A..D is a new vector to check.
- A  input  1  stimulus bit 0.
- B  input  1  stimulus bit 1.
- C  input  1  stimulus bit 2.
- D  input  1  stimulus bit 3.
- E  input  1  DUT response, expected A|B.
- F  input  1  DUT response, expected C|D.
- G  input  1  DUT response, expected E|F.
- BUSY  output  1  high in ARMED, SETTLE and CHECK.
- DONE  output  1  high in the DONE state.
- PASS  output  1  high in DONE only when ERR_CNT == 0.
- ERR_CNT  output  ERR_W  mismatching vectors this run; saturates at all-ones.
- SAMPLE_CNT  output  8  vectors checked this run.
- FIRST_ERR  output  7  {A,B,C,D,E,F,G} of the first mismatching check.
- ERR_VALID  output  1  FIRST_ERR holds a captured vector.

Behaviour:
Reset:
- RST asserted, asynchronous: state = IDLE.
- BUSY, DONE, PASS and ERR_VALID = 0.
- ERR_CNT, SAMPLE_CNT and FIRST_ERR = 0.
- Internal stimulus latch and settle counter = 0.
- RST asserted mid-run abandons the run immediately; no partial result is kept.

States:
- IDLE: outputs hold their reset values. START -> ARMED; on that edge, clear ERR_CNT, SAMPLE_CNT, FIRST_ERR and ERR_VALID.
- ARMED: waits for STROBE. On STROBE, latch {A,B,C,D} into stim_q, load the settle counter with SETTLE-1, and go to SETTLE.
- SETTLE: the counter decrements each cycle; at 0, go to CHECK. SETTLE=1 gives one cycle in this state. STROBE pulses arriving here or in CHECK are ignored and not queued.
- CHECK: one cycle.
  - exp_E = stim_q[A]|stim_q[B], exp_F = stim_q[C]|stim_q[D], exp_G = exp_E|exp_F.
  - A mismatch is any of E/F/G differing from its expected value.
  - On mismatch, ERR_CNT increments and saturates at 2^ERR_W-1.
  - On mismatch with ERR_VALID = 0, FIRST_ERR <= {stim_q, E, F, G} and ERR_VALID <= 1.
  - SAMPLE_CNT increments in all cases.
  - If the new SAMPLE_CNT == NUM_SAMPLES -> DONE; otherwise -> ARMED.
- DONE: DONE = 1 and PASS = (ERR_CNT == 0); all counters hold. START -> ARMED, clearing them as from IDLE.

Simultaneous events and timing:
- START is ignored while BUSY.
- START and STROBE in the same IDLE cycle: START wins; that STROBE is not captured.
- Latency: STROBE at edge n is compared at edge n+SETTLE+1. E/F/G are sampled on that CHECK edge, and the counters update on the same edge.
- All outputs are registered; nothing is combinational from the inputs.

Test Plan:
- Good DUT, NUM_SAMPLES=16, SETTLE=2: START, then walk A..D through 0000..1111 with one STROBE each 4 cycles, and drive E/F/G as the correct OR functions. Required: DONE=1, PASS=1, ERR_CNT=0, SAMPLE_CNT=16, ERR_VALID=0.
- Stuck-at-0 G: same stimulus with G tied to 0. Required: ERR_CNT=15, PASS=0, FIRST_ERR=7'b0001_010 (stimulus 0001: E=0, F=1, G=0), ERR_VALID=1.
- Latency check: STROBE at cycle 10 with A=1. Required: SAMPLE_CNT goes to 1 on the edge at cycle 13 and not before. A second STROBE at cycle 11 is ignored, so SAMPLE_CNT stays 1 until the next ARMED-state STROBE.
- Reset mid-run: after 5 checks, 2 of them failing, assert RST asynchronously between edges. Required:
  - Immediately: ERR_CNT=0, SAMPLE_CNT=0, BUSY=0, ERR_VALID=0.
  - After a new START and 16 good vectors: PASS=1.
- Restart from DONE: after a failing run (PASS=0, ERR_CNT=3), pulse START. Required: the next cycle shows BUSY=1, DONE=0, ERR_CNT=0, ERR_VALID=0. A clean run then ends with PASS=1.
- Saturation, ERR_W=2 and NUM_SAMPLES=8: F inverted on every vector. Required: ERR_CNT ends at 3 (saturated, not wrapped), SAMPLE_CNT=8, PASS=0.

Source files
------------

// File: rtl/or4_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : or4_response_checker
// Brief    : Observing-end monitor for the four-input OR-gate test interface.
//            Latches each strobed A..D vector, waits a settle interval, then
//            checks E/F/G against locally computed OR results, counting
//            samples and mismatches and capturing the first failing vector.
// Revision : 1.0 - initial release
// ============================================================================
module or4_response_checker #(
    parameter int NUM_SAMPLES = 16,
    parameter int SETTLE      = 2,
    parameter int ERR_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STROBE,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    input  logic             F,
    input  logic             G,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [7:0]       SAMPLE_CNT,
    output logic [6:0]       FIRST_ERR,
    output logic             ERR_VALID
);

    localparam logic [3:0]       c_SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [7:0]       c_NUM_SAMPLES = 8'(NUM_SAMPLES);
    localparam logic [ERR_W-1:0] c_ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] c_ERR_ONE     = ERR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_stim;
    logic [3:0]       r_settle;
    logic             w_start_ok;
    logic             w_exp_e;
    logic             w_exp_f;
    logic             w_exp_g;
    logic             w_mismatch;
    logic [7:0]       w_sample_inc;
    logic [ERR_W-1:0] w_err_next;

    // START only takes effect when no run is in progress.
    assign w_start_ok   = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Expected gate responses from the latched vector {A,B,C,D}.
    assign w_exp_e      = r_stim[3] | r_stim[2];
    assign w_exp_f      = r_stim[1] | r_stim[0];
    assign w_exp_g      = w_exp_e | w_exp_f;
    assign w_mismatch   = (E != w_exp_e) || (F != w_exp_f) || (G != w_exp_g);
    assign w_sample_inc = SAMPLE_CNT + 8'd1;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; START beats a coincident STROBE because IDLE/DONE
    // never look at STROBE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (START) w_next_state = ST_ARMED;
            ST_ARMED:  if (STROBE) w_next_state = ST_SETTLE;
            ST_SETTLE: if (r_settle == 4'd0) w_next_state = ST_CHECK;
            ST_CHECK:  w_next_state = (w_sample_inc == c_NUM_SAMPLES) ? ST_DONE : ST_ARMED;
            ST_DONE:   if (START) w_next_state = ST_ARMED;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Error count after this cycle; shared by the counter and the PASS flag.
    always_comb begin
        w_err_next = ERR_CNT;
        if (w_start_ok) begin
            w_err_next = '0;
        end else if ((r_state == ST_CHECK) && w_mismatch && (ERR_CNT != c_ERR_MAX)) begin
            w_err_next = ERR_CNT + c_ERR_ONE;
        end
    end

    // Stimulus latch and settle countdown.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stim   <= 4'd0;
            r_settle <= 4'd0;
        end else if ((r_state == ST_ARMED) && STROBE) begin
            r_stim   <= {A, B, C, D};
            r_settle <= c_SETTLE_LOAD;
        end else if ((r_state == ST_SETTLE) && (r_settle != 4'd0)) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    // Run counters and first-failure capture, cleared by an accepted START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_CNT    <= '0;
            SAMPLE_CNT <= 8'd0;
            FIRST_ERR  <= 7'd0;
            ERR_VALID  <= 1'b0;
        end else begin
            ERR_CNT <= w_err_next;
            if (w_start_ok) begin
                SAMPLE_CNT <= 8'd0;
                FIRST_ERR  <= 7'd0;
                ERR_VALID  <= 1'b0;
            end else if (r_state == ST_CHECK) begin
                SAMPLE_CNT <= w_sample_inc;
                if (w_mismatch && !ERR_VALID) begin
                    FIRST_ERR <= {r_stim, E, F, G};
                    ERR_VALID <= 1'b1;
                end
            end
        end
    end

    // Status flags registered from the upcoming state so they align with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
        end else begin
            BUSY <= (w_next_state == ST_ARMED) || (w_next_state == ST_SETTLE) ||
                    (w_next_state == ST_CHECK);
            DONE <= (w_next_state == ST_DONE);
            PASS <= (w_next_state == ST_DONE) && (w_err_next == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_or4_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_or4_response_checker
// Brief    : Self-checking bench for or4_response_checker with a scoreboard
//            model of the run counters and first-failure capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_or4_response_checker;

    localparam int c_SETTLE = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic START = 1'b0;
    logic STROBE = 1'b0;
    logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic E = 1'b0, F = 1'b0, G = 1'b0;

    logic       busy1, done1, pass1, ev1;
    logic [7:0] err1, smp1;
    logic [6:0] ferr1;
    logic       busy2, done2, pass2, ev2;
    logic [1:0] err2;
    logic [7:0] smp2;
    logic [6:0] ferr2;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard for the 16-sample checker.
    int         m_err;
    int         m_smp;
    logic [6:0] m_first;
    logic       m_valid;

    or4_response_checker #(.NUM_SAMPLES(16), .SETTLE(c_SETTLE), .ERR_W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STROBE(STROBE),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
        .SAMPLE_CNT(smp1), .FIRST_ERR(ferr1), .ERR_VALID(ev1)
    );

    or4_response_checker #(.NUM_SAMPLES(8), .SETTLE(c_SETTLE), .ERR_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .START(START), .STROBE(STROBE),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2),
        .SAMPLE_CNT(smp2), .FIRST_ERR(ferr2), .ERR_VALID(ev2)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_start();
        m_err   = 0;
        m_smp   = 0;
        m_first = 7'd0;
        m_valid = 1'b0;
    endtask

    task automatic do_start();
        START = 1'b1;
        tick();
        START = 1'b0;
        model_start();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    // Present one vector {A,B,C,D}=v with responses = correct OR results ^ flip,
    // then wait out settle + check before the next vector may be strobed.
    task automatic send_vec(input logic [3:0] v, input logic [2:0] flip, input int gap);
        logic       ex_e, ex_f, ex_g;
        logic [2:0] resp;
        ex_e = v[3] | v[2];
        ex_f = v[1] | v[0];
        ex_g = ex_e | ex_f;
        resp = {ex_e, ex_f, ex_g} ^ flip;
        {A, B, C, D} = v;
        {E, F, G}    = resp;
        STROBE = 1'b1;
        tick();
        STROBE = 1'b0;
        repeat (c_SETTLE + 1 + gap) tick();
        m_smp++;
        if (resp != {ex_e, ex_f, ex_g}) begin
            if (m_err < 255) m_err++;
            if (!m_valid) begin
                m_first = {v, resp};
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy1); else n_pass++;
        n_checks++; if (done1 !== 1'b0) $display("FAIL reset_done got %b exp 0", done1); else n_pass++;
        n_checks++; if (pass1 !== 1'b0) $display("FAIL reset_pass got %b exp 0", pass1); else n_pass++;
        n_checks++; if (err1 !== 8'd0) $display("FAIL reset_err got %0d exp 0", err1); else n_pass++;
        n_checks++; if (smp1 !== 8'd0) $display("FAIL reset_smp got %0d exp 0", smp1); else n_pass++;
        n_checks++; if (ferr1 !== 7'd0) $display("FAIL reset_ferr got %b exp 0", ferr1); else n_pass++;
        n_checks++; if (ev1 !== 1'b0) $display("FAIL reset_ev got %b exp 0", ev1); else n_pass++;
        n_checks++; if (err2 !== 2'd0) $display("FAIL reset_err_sat got %0d exp 0", err2); else n_pass++;
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_good_walk();
        do_start();
        for (int v = 0; v < 16; v++) send_vec(4'(v), 3'b000, 0);
        n_checks++; if (done1 !== 1'b1) $display("FAIL good_done got %b exp 1", done1); else n_pass++;
        n_checks++; if (pass1 !== 1'b1) $display("FAIL good_pass got %b exp 1", pass1); else n_pass++;
        n_checks++; if (err1 !== 8'd0) $display("FAIL good_err got %0d exp 0", err1); else n_pass++;
        n_checks++; if (smp1 !== 8'd16) $display("FAIL good_smp got %0d exp 16", smp1); else n_pass++;
        n_checks++; if (ev1 !== 1'b0) $display("FAIL good_ev got %b exp 0", ev1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL good_busy got %b exp 0", busy1); else n_pass++;
    endtask

    task automatic test_stuck_g();
        logic [3:0] vv;
        do_start();
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            send_vec(vv, {2'b00, |vv}, 0);
        end
        n_checks++; if (err1 !== 8'd15) $display("FAIL stuck_err got %0d exp 15", err1); else n_pass++;
        n_checks++; if (pass1 !== 1'b0) $display("FAIL stuck_pass got %b exp 0", pass1); else n_pass++;
        n_checks++; if (ferr1 !== 7'b0001010) $display("FAIL stuck_ferr got %b exp 0001010", ferr1); else n_pass++;
        n_checks++; if (ev1 !== 1'b1) $display("FAIL stuck_ev got %b exp 1", ev1); else n_pass++;
        n_checks++; if (done1 !== 1'b1) $display("FAIL stuck_done got %b exp 1", done1); else n_pass++;
    endtask

    task automatic test_latency();
        pulse_reset();
        // START with a coincident STROBE: the strobe must not be captured.
        {A, B, C, D} = 4'b1000;
        {E, F, G}    = 3'b101;
        START = 1'b1;
        STROBE = 1'b1;
        tick();
        START = 1'b0;
        STROBE = 1'b0;
        repeat (4) tick();
        n_checks++; if (smp1 !== 8'd0) $display("FAIL startstrobe_smp got %0d exp 0", smp1); else n_pass++;
        n_checks++; if (busy1 !== 1'b1) $display("FAIL startstrobe_busy got %b exp 1", busy1); else n_pass++;
        // Strobe at edge n, a second one at n+1 while settling.
        STROBE = 1'b1;
        tick();
        n_checks++; if (smp1 !== 8'd0) $display("FAIL lat_n0 got %0d exp 0", smp1); else n_pass++;
        {A, B, C, D} = 4'b0001;
        tick();
        STROBE = 1'b0;
        n_checks++; if (smp1 !== 8'd0) $display("FAIL lat_n1 got %0d exp 0", smp1); else n_pass++;
        tick();
        n_checks++; if (smp1 !== 8'd0) $display("FAIL lat_n2 got %0d exp 0", smp1); else n_pass++;
        tick();
        n_checks++; if (smp1 !== 8'd1) $display("FAIL lat_n3 got %0d exp 1", smp1); else n_pass++;
        repeat (4) tick();
        n_checks++; if (smp1 !== 8'd1) $display("FAIL lat_hold got %0d exp 1", smp1); else n_pass++;
        n_checks++; if (err1 !== 8'd0) $display("FAIL lat_ignored_err got %0d exp 0", err1); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        pulse_reset();
        do_start();
        for (int i = 0; i < 5; i++)
            send_vec(4'($urandom_range(0, 15)), (i == 1 || i == 3) ? 3'($urandom_range(1, 7)) : 3'b000, 0);
        n_checks++; if (err1 !== 8'(m_err)) $display("FAIL mid_err got %0d exp %0d", err1, m_err); else n_pass++;
        #2;
        RST = 1'b1;
        #1;
        n_checks++; if (err1 !== 8'd0) $display("FAIL mid_rst_err got %0d exp 0", err1); else n_pass++;
        n_checks++; if (smp1 !== 8'd0) $display("FAIL mid_rst_smp got %0d exp 0", smp1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy1); else n_pass++;
        n_checks++; if (ev1 !== 1'b0) $display("FAIL mid_rst_ev got %b exp 0", ev1); else n_pass++;
        tick();
        RST = 1'b0;
        tick();
        do_start();
        for (int i = 0; i < 16; i++) send_vec(4'($urandom_range(0, 15)), 3'b000, 0);
        n_checks++; if (pass1 !== 1'b1) $display("FAIL mid_rerun_pass got %b exp 1", pass1); else n_pass++;
        n_checks++; if (done1 !== 1'b1) $display("FAIL mid_rerun_done got %b exp 1", done1); else n_pass++;
    endtask

    task automatic test_restart_from_done();
        int k;
        k = $urandom_range(0, 5);
        do_start();
        for (int i = 0; i < 16; i++)
            send_vec(4'($urandom_range(0, 15)),
                     (i == k || i == k + 5 || i == k + 10) ? 3'($urandom_range(1, 7)) : 3'b000, 0);
        n_checks++; if (pass1 !== 1'b0) $display("FAIL restart_fail_pass got %b exp 0", pass1); else n_pass++;
        n_checks++; if (err1 !== 8'd3) $display("FAIL restart_fail_err got %0d exp 3", err1); else n_pass++;
        n_checks++; if (ferr1 !== m_first) $display("FAIL restart_fail_ferr got %b exp %b", ferr1, m_first); else n_pass++;
        do_start();
        n_checks++; if (busy1 !== 1'b1) $display("FAIL restart_busy got %b exp 1", busy1); else n_pass++;
        n_checks++; if (done1 !== 1'b0) $display("FAIL restart_done got %b exp 0", done1); else n_pass++;
        n_checks++; if (err1 !== 8'd0) $display("FAIL restart_err got %0d exp 0", err1); else n_pass++;
        n_checks++; if (ev1 !== 1'b0) $display("FAIL restart_ev got %b exp 0", ev1); else n_pass++;
        for (int i = 0; i < 16; i++) send_vec(4'($urandom_range(0, 15)), 3'b000, 0);
        n_checks++; if (pass1 !== 1'b1) $display("FAIL restart_clean_pass got %b exp 1", pass1); else n_pass++;
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            do_start();
            for (int i = 0; i < 16; i++)
                send_vec(4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                         $urandom_range(0, 2));
            n_checks++; if (err1 !== 8'(m_err)) $display("FAIL rand%0d_err got %0d exp %0d", r, err1, m_err); else n_pass++;
            n_checks++; if (smp1 !== 8'(m_smp)) $display("FAIL rand%0d_smp got %0d exp %0d", r, smp1, m_smp); else n_pass++;
            n_checks++; if (ferr1 !== m_first) $display("FAIL rand%0d_ferr got %b exp %b", r, ferr1, m_first); else n_pass++;
            n_checks++; if (ev1 !== m_valid) $display("FAIL rand%0d_ev got %b exp %b", r, ev1, m_valid); else n_pass++;
            n_checks++; if (pass1 !== (m_err == 0)) $display("FAIL rand%0d_pass got %b exp %b", r, pass1, (m_err == 0)); else n_pass++;
            n_checks++; if (done1 !== 1'b1) $display("FAIL rand%0d_done got %b exp 1", r, done1); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [3:0] v0;
        logic [6:0] exp_first;
        pulse_reset();
        do_start();
        v0 = 4'($urandom_range(0, 15));
        exp_first = {v0, (v0[3] | v0[2]), ~(v0[1] | v0[0]), |v0};
        send_vec(v0, 3'b010, 0);
        for (int i = 1; i < 8; i++) send_vec(4'($urandom_range(0, 15)), 3'b010, 0);
        n_checks++; if (err2 !== 2'd3) $display("FAIL sat_err got %0d exp 3", err2); else n_pass++;
        n_checks++; if (smp2 !== 8'd8) $display("FAIL sat_smp got %0d exp 8", smp2); else n_pass++;
        n_checks++; if (pass2 !== 1'b0) $display("FAIL sat_pass got %b exp 0", pass2); else n_pass++;
        n_checks++; if (done2 !== 1'b1) $display("FAIL sat_done got %b exp 1", done2); else n_pass++;
        n_checks++; if (ferr2 !== exp_first) $display("FAIL sat_ferr got %b exp %b", ferr2, exp_first); else n_pass++;
        n_checks++; if (ev2 !== 1'b1) $display("FAIL sat_ev got %b exp 1", ev2); else n_pass++;
    endtask

    initial begin
        model_start();
        test_reset();
        test_good_walk();
        test_stuck_g();
        test_latency();
        test_reset_midrun();
        test_restart_from_done();
        test_random_runs();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
